// File: rtl/zb_fifo_pkg.sv
// Shared definitions for the inFIFO symbol path: reader FSM states and the
// symbol width agreed between inFIFO and its consumer.
package zb_fifo_pkg;

    localparam int SYMBOL_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        SHIFT = 2'd3
    } reader_state_t;

endpackage

// File: rtl/fifo_symbol_reader_if.sv
// Signal bundle between inFIFO / TX chain and the symbol reader.
// master is the reader's view, slave is the FIFO/TX side.
interface fifo_symbol_reader_if #(
    parameter int DATA_WIDTH  = zb_fifo_pkg::SYMBOL_WIDTH,
    parameter int COUNT_WIDTH = 8
);
    logic                   inEnable;
    logic                   inFifoEmpty;
    logic                   inFifoReadError;
    logic [DATA_WIDTH-1:0]  inFifoData;
    logic                   outFifoReadEnable;
    logic                   outBit;
    logic                   outBitStrobe;
    logic                   outSymbolDone;
    logic                   outBusy;
    logic                   outUnderflow;
    logic [COUNT_WIDTH-1:0] outSymbolCount;

    modport master (
        input  inEnable, inFifoEmpty, inFifoReadError, inFifoData,
        output outFifoReadEnable, outBit, outBitStrobe, outSymbolDone,
               outBusy, outUnderflow, outSymbolCount
    );

    modport slave (
        output inEnable, inFifoEmpty, inFifoReadError, inFifoData,
        input  outFifoReadEnable, outBit, outBitStrobe, outSymbolDone,
               outBusy, outUnderflow, outSymbolCount
    );
endinterface

// File: rtl/fifo_symbol_reader_bit_pacer.sv
// Bit period timer: down-counter reloaded on symbol start and on every
// terminal count; emits the end-of-period tick and a registered new-bit strobe.
module bit_pacer #(
    parameter int BIT_PERIOD = 8
) (
    input  logic inClock,
    input  logic inReset,
    input  logic inStart,
    input  logic inRun,
    input  logic inFinalBit,
    output logic outTick,
    output logic outStrobe
);
    localparam int PW = $clog2(BIT_PERIOD);

    logic [PW-1:0] periodCount;

    assign outTick = inRun && (periodCount == '0);

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            periodCount <= '0;
            outStrobe   <= 1'b0;
        end else begin
            // no strobe after the final bit: the next one comes from inStart
            outStrobe <= inStart || (outTick && !inFinalBit);
            if (inStart || outTick) begin
                periodCount <= PW'(BIT_PERIOD - 1);
            end else if (inRun) begin
                periodCount <= periodCount - 1'b1;
            end
        end
    end
endmodule

// File: rtl/fifo_symbol_reader.sv
// inFIFO consumer: strobes one read per symbol, captures the data after the
// FIFO read latency and serializes it as a paced bit stream to the spreader.
//
// state | meaning
// IDLE  | waiting for enable and a non-empty FIFO
// REQ   | single-cycle FIFO read strobe
// WAIT  | read latency elapsing, capture data/error on its last cycle
// SHIFT | serializing DATA_WIDTH bits, BIT_PERIOD clocks each
module fifo_symbol_reader
    import zb_fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = SYMBOL_WIDTH,
    parameter int BIT_PERIOD   = 8,
    parameter int READ_LATENCY = 1,
    parameter int COUNT_WIDTH  = 8,
    parameter bit MSB_FIRST    = 1'b0
) (
    input logic inClock,
    input logic inReset,
    fifo_symbol_reader_if.master bus
);
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int LAT_W = 2;

    reader_state_t          state;
    reader_state_t          stateNext;
    logic [DATA_WIDTH-1:0]  shiftReg;
    logic [BIT_W-1:0]       bitIndex;
    logic [LAT_W-1:0]       latCount;
    logic [COUNT_WIDTH-1:0] symbolCount;
    logic                   symbolDone;
    logic                   underflow;
    logic                   fifoReadEnable;
    logic                   busy;
    logic                   startNext;
    logic                   lastWait;
    logic                   capture;
    logic                   captureError;
    logic                   finalBit;
    logic                   bitTick;
    logic                   bitStrobe;
    logic                   symbolEnd;

    assign startNext    = bus.inEnable && !bus.inFifoEmpty;
    assign lastWait     = (state == WAIT) && (latCount == '0);
    assign capture      = lastWait && !bus.inFifoReadError;
    assign captureError = lastWait && bus.inFifoReadError;
    assign finalBit     = (bitIndex == BIT_W'(DATA_WIDTH - 1));
    assign symbolEnd    = bitTick && finalBit;

    bit_pacer #(.BIT_PERIOD(BIT_PERIOD)) u_bit_pacer (
        .inClock    (inClock),
        .inReset    (inReset),
        .inStart    (capture),
        .inRun      (state == SHIFT),
        .inFinalBit (finalBit),
        .outTick    (bitTick),
        .outStrobe  (bitStrobe)
    );

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext      = state;
        fifoReadEnable = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (startNext) stateNext = REQ;
            end
            REQ: begin
                fifoReadEnable = 1'b1;
                stateNext      = WAIT;
            end
            WAIT: begin
                if (lastWait) stateNext = bus.inFifoReadError ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (symbolEnd) stateNext = startNext ? REQ : IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            shiftReg    <= '0;
            bitIndex    <= '0;
            latCount    <= '0;
            symbolCount <= '0;
            symbolDone  <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            symbolDone <= symbolEnd;
            if (symbolEnd)    symbolCount <= symbolCount + 1'b1;
            if (captureError) underflow   <= 1'b1;

            if (state == REQ)                      latCount <= LAT_W'(READ_LATENCY - 1);
            else if (state == WAIT && latCount != '0) latCount <= latCount - 1'b1;

            // the final bit is never shifted away, so outBit holds it until the next capture
            if (capture) begin
                shiftReg <= bus.inFifoData;
                bitIndex <= '0;
            end else if (bitTick && !finalBit) begin
                shiftReg <= MSB_FIRST ? (shiftReg << 1) : (shiftReg >> 1);
                bitIndex <= bitIndex + 1'b1;
            end
        end
    end

    assign bus.outFifoReadEnable = fifoReadEnable;
    assign bus.outBit            = MSB_FIRST ? shiftReg[DATA_WIDTH-1] : shiftReg[0];
    assign bus.outBitStrobe      = bitStrobe;
    assign bus.outSymbolDone     = symbolDone;
    assign bus.outBusy           = busy;
    assign bus.outUnderflow      = underflow;
    assign bus.outSymbolCount    = symbolCount;
endmodule
